bist_adder_n: RTL and testbench

- Parametrised BIST wrapper around a WIDTH-bit ripple-carry adder CUT with per-bit fault injection.
- On start, an exhaustive pattern counter drives the CUT, and a fault-free golden adder is evaluated in parallel.
- Every mismatch is counted, the first failing pattern is captured, and the CUT responses are compacted into a MISR signature.
- Outside test, the CUT serves the functional a/b/cin path.

---
 rtl/bist_adder_n.sv | 184 ++++++++++++++++++
 tb/tb_bist_adder_n.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/bist_adder_n.sv
// Built-in self-test wrapper around a fault-injectable ripple-carry adder.
// An exhaustive pattern sweep is scored against a golden adder, and the responses are compacted into a MISR.
module bist_adder_n #(
    parameter int unsigned      WIDTH     = 4,
    parameter int unsigned      PATTERNS  = 2**(2*WIDTH+1),
    parameter logic [WIDTH:0]   MISR_POLY = (WIDTH+1)'(3)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [WIDTH-1:0]     func_a,
    input  logic [WIDTH-1:0]     func_b,
    input  logic                 func_cin,
    input  logic [WIDTH-1:0]     sa0_a_mask,
    input  logic [WIDTH-1:0]     sa1_sum_mask,
    input  logic [WIDTH-1:0]     sa0_gen_mask,
    output logic [WIDTH-1:0]     func_sum,
    output logic                 func_cout,
    output logic                 busy,
    output logic                 done,
    output logic                 pass,
    output logic [2*WIDTH+1:0]   fail_count,
    output logic                 first_fail_valid,
    output logic [2*WIDTH:0]     first_fail_pattern,
    output logic [WIDTH:0]       signature
);

    localparam int unsigned PW = 2*WIDTH + 1;
    localparam int unsigned FW = 2*WIDTH + 2;
    localparam int unsigned SW = WIDTH + 1;
    localparam logic [PW-1:0] PAT_LAST = PW'(PATTERNS - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_INIT = 2'd1,
        S_RUN  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t state;
    state_t state_d;

    logic [PW-1:0]    pat;
    logic [PW-1:0]    pat_d;
    logic [FW-1:0]    fail_d;
    logic             ffv_d;
    logic [PW-1:0]    ffp_d;
    logic [SW-1:0]    sig_d;
    logic             pass_d;
    logic             busy_d;
    logic             done_d;

    logic [WIDTH-1:0] cut_a;
    logic [WIDTH-1:0] cut_b;
    logic             cut_cin;
    logic [WIDTH-1:0] a1;
    logic [WIDTH-1:0] prop;
    logic [WIDTH-1:0] gen;
    logic [WIDTH-1:0] cut_sum;
    logic [WIDTH:0]   carry;
    logic [SW-1:0]    resp;
    logic [SW-1:0]    gold;
    logic             mismatch;
    logic [SW-1:0]    sig_shift;

    // CUT input mux: the pattern register only owns the adder while running
    always_comb begin : cut_mux
        cut_a   = func_a;
        cut_b   = func_b;
        cut_cin = func_cin;
        if (state == S_RUN) begin
            cut_a   = pat[WIDTH-1:0];
            cut_b   = pat[2*WIDTH-1:WIDTH];
            cut_cin = pat[2*WIDTH];
        end
    end

    // Gate-level ripple adder with stuck-at fault injection on a, sum and generate
    always_comb begin : cut
        a1       = '0;
        prop     = '0;
        gen      = '0;
        cut_sum  = '0;
        carry    = '0;
        carry[0] = cut_cin;
        for (int i = 0; i < int'(WIDTH); i++) begin
            a1[i]      = cut_a[i] & ~sa0_a_mask[i];
            prop[i]    = a1[i] ^ cut_b[i];
            cut_sum[i] = (prop[i] ^ carry[i]) | sa1_sum_mask[i];
            gen[i]     = (a1[i] & cut_b[i]) & ~sa0_gen_mask[i];
            carry[i+1] = (prop[i] & carry[i]) | gen[i];
        end
    end

    assign func_sum  = cut_sum;
    assign func_cout = carry[WIDTH];

    assign resp      = {carry[WIDTH], cut_sum};
    assign gold      = SW'(cut_a) + SW'(cut_b) + SW'(cut_cin);
    assign mismatch  = (resp != gold);
    assign sig_shift = {signature[WIDTH-1:0], 1'b0} ^ (signature[WIDTH] ? MISR_POLY : '0);

    always_ff @(posedge clk or negedge rst_n) begin : state_reg
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_d;
        end
    end

    always_comb begin : next_state
        state_d = state;
        case (state)
            S_IDLE:  if (start) state_d = S_INIT;
            S_INIT:  state_d = S_RUN;
            S_RUN:   if (pat == PAT_LAST) state_d = S_DONE;
            S_DONE:  if (start) state_d = S_INIT;
            default: state_d = S_IDLE;
        endcase
    end

    // Next values of the result registers; pass is resolved on the final RUN cycle
    always_comb begin : outputs
        pat_d  = pat;
        fail_d = fail_count;
        ffv_d  = first_fail_valid;
        ffp_d  = first_fail_pattern;
        sig_d  = signature;
        pass_d = pass;
        case (state)
            S_INIT: begin
                pat_d  = '0;
                fail_d = '0;
                ffv_d  = 1'b0;
                ffp_d  = '0;
                sig_d  = '0;
                pass_d = 1'b0;
            end
            S_RUN: begin
                sig_d = sig_shift ^ resp;
                if (mismatch) begin
                    if (fail_count != '1) begin
                        fail_d = fail_count + FW'(1);
                    end
                    if (!first_fail_valid) begin
                        ffv_d = 1'b1;
                        ffp_d = pat;
                    end
                end
                if (pat == PAT_LAST) begin
                    pass_d = (fail_d == '0);
                end else begin
                    pat_d = pat + PW'(1);
                end
            end
            default: ;
        endcase
        busy_d = (state_d == S_INIT) || (state_d == S_RUN);
        done_d = (state_d == S_DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin : result_reg
        if (!rst_n) begin
            pat                <= '0;
            fail_count         <= '0;
            first_fail_valid   <= 1'b0;
            first_fail_pattern <= '0;
            signature          <= '0;
            pass               <= 1'b0;
            busy               <= 1'b0;
            done               <= 1'b0;
        end else begin
            pat                <= pat_d;
            fail_count         <= fail_d;
            first_fail_valid   <= ffv_d;
            first_fail_pattern <= ffp_d;
            signature          <= sig_d;
            pass               <= pass_d;
            busy               <= busy_d;
            done               <= done_d;
        end
    end

endmodule

// File: tb/tb_bist_adder_n.sv
// Self-checking bench for bist_adder_n (WIDTH=4): table-driven BIST runs, randomized
// fault masks against an arithmetic reference model, functional path and mid-run reset.
module tb_bist_adder_n;

    localparam int W    = 4;
    localparam int NPAT = 512;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [W-1:0]  func_a = '0;
    logic [W-1:0]  func_b = '0;
    logic          func_cin = 1'b0;
    logic [W-1:0]  sa0_a_mask = '0;
    logic [W-1:0]  sa1_sum_mask = '0;
    logic [W-1:0]  sa0_gen_mask = '0;
    logic [W-1:0]  func_sum;
    logic          func_cout;
    logic          busy;
    logic          done;
    logic          pass;
    logic [2*W+1:0] fail_count;
    logic          first_fail_valid;
    logic [2*W:0]  first_fail_pattern;
    logic [W:0]    signature;

    int n_total = 0;
    int n_pass  = 0;

    bist_adder_n #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .func_a(func_a), .func_b(func_b), .func_cin(func_cin),
        .sa0_a_mask(sa0_a_mask), .sa1_sum_mask(sa1_sum_mask), .sa0_gen_mask(sa0_gen_mask),
        .func_sum(func_sum), .func_cout(func_cout),
        .busy(busy), .done(done), .pass(pass), .fail_count(fail_count),
        .first_fail_valid(first_fail_valid), .first_fail_pattern(first_fail_pattern),
        .signature(signature)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] m_a;
        logic [W-1:0] m_s;
        logic [W-1:0] m_g;
        int           exp_fail;
        bit           exp_ffv;
        int           exp_ffp;
        bit           exp_pass;
    } vec_t;

    task automatic check(input string name, input longint act, input longint exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    // Faulty adder expressed arithmetically: a dead generate term with a=b=1 behaves like a=b=0 in that bit
    function automatic logic [W:0] model_resp(input logic [W-1:0] a, input logic [W-1:0] b,
                                              input logic cin, input logic [W-1:0] ma,
                                              input logic [W-1:0] ms, input logic [W-1:0] mg);
        logic [W-1:0] aa, bb, kill;
        logic [W:0]   r;
        aa   = a & ~ma;
        kill = aa & b & mg;
        aa   = aa & ~kill;
        bb   = b & ~kill;
        r    = {1'b0, aa} + {1'b0, bb} + {{W{1'b0}}, cin};
        r[W-1:0] = r[W-1:0] | ms;
        return r;
    endfunction

    function automatic void model_run(input logic [W-1:0] ma, input logic [W-1:0] ms,
                                      input logic [W-1:0] mg, output int fails, output bit ffv,
                                      output int ffp, output logic [W:0] sig);
        logic [2*W:0] pv;
        logic [W:0]   r, g;
        fails = 0; ffv = 0; ffp = 0; sig = '0;
        for (int p = 0; p < NPAT; p++) begin
            pv  = (2*W+1)'(p);
            r   = model_resp(pv[W-1:0], pv[2*W-1:W], pv[2*W], ma, ms, mg);
            g   = (W+1)'(pv[W-1:0]) + (W+1)'(pv[2*W-1:W]) + (W+1)'(pv[2*W]);
            sig = ({sig[W-1:0], 1'b0} ^ (sig[W] ? 5'h03 : 5'h00)) ^ r;
            if (r != g) begin
                fails++;
                if (!ffv) begin ffv = 1; ffp = p; end
            end
        end
    endfunction

    // Pulse start, optionally re-pulse it mid-RUN, and count busy cycles until done
    task automatic run_bist(input bit mid_start, output int bc, output bit timed_out);
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        bc = 0;
        timed_out = 1;
        for (int k = 0; k < 2000; k++) begin
            @(negedge clk);
            if (busy) bc++;
            start = (mid_start && bc == 200);
            if (done) begin timed_out = 0; break; end
        end
        start = 1'b0;
        check("run_timeout", timed_out, 0);
    endtask

    task automatic check_results(input string tag, input int efail, input bit effv,
                                 input int effp, input bit epass, input logic [W:0] esig);
        check({tag, "_done"}, done, 1);
        check({tag, "_pass"}, pass, epass);
        check({tag, "_fail_count"}, fail_count, efail);
        check({tag, "_ffv"}, first_fail_valid, effv);
        if (effv) check({tag, "_ffp"}, first_fail_pattern, effp);
        check({tag, "_signature"}, signature, esig);
    endtask

    vec_t        tbl[4];
    logic [W:0]  dut_sig[4];

    initial begin
        int         bc, mfail, mffp;
        bit         to, mffv;
        logic [W:0] msig, r;
        logic [W-1:0] ra, rb, rma, rms, rmg;
        logic       rc;

        tbl[0] = '{m_a:4'h0, m_s:4'h0, m_g:4'h0, exp_fail:0,   exp_ffv:0, exp_ffp:0,  exp_pass:1};
        tbl[1] = '{m_a:4'h0, m_s:4'h1, m_g:4'h0, exp_fail:256, exp_ffv:1, exp_ffp:0,  exp_pass:0};
        tbl[2] = '{m_a:4'h1, m_s:4'h0, m_g:4'h0, exp_fail:256, exp_ffv:1, exp_ffp:1,  exp_pass:0};
        tbl[3] = '{m_a:4'h0, m_s:4'h0, m_g:4'h1, exp_fail:128, exp_ffv:1, exp_ffp:17, exp_pass:0};

        repeat (3) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_pass", pass, 0);
        check("rst_fail_count", fail_count, 0);
        check("rst_ffv", first_fail_valid, 0);
        check("rst_ffp", first_fail_pattern, 0);
        check("rst_signature", signature, 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check("idle_busy", busy, 0);

        // Functional path
        func_a = 4'd3; func_b = 4'd5; func_cin = 1'b1;
        #1;
        check("func_sum_3_5_1", func_sum, 9);
        check("func_cout_3_5_1", func_cout, 0);
        for (int i = 0; i < 24; i++) begin
            ra = 4'($urandom); rb = 4'($urandom); rc = 1'($urandom);
            rma = (i < 8) ? 4'h0 : 4'($urandom); rms = (i < 12) ? 4'h0 : 4'($urandom);
            rmg = 4'($urandom);
            func_a = ra; func_b = rb; func_cin = rc;
            sa0_a_mask = rma; sa1_sum_mask = rms; sa0_gen_mask = rmg;
            #1;
            r = model_resp(ra, rb, rc, rma, rms, rmg);
            check("func_rand", {func_cout, func_sum}, r);
        end
        func_a = '0; func_b = '0; func_cin = 1'b0;

        // Table-driven BIST runs; a stray start is pulsed mid-RUN each time
        for (int t = 0; t < 4; t++) begin
            sa0_a_mask = tbl[t].m_a; sa1_sum_mask = tbl[t].m_s; sa0_gen_mask = tbl[t].m_g;
            model_run(tbl[t].m_a, tbl[t].m_s, tbl[t].m_g, mfail, mffv, mffp, msig);
            run_bist(1'b1, bc, to);
            check("busy_cycles", bc, NPAT + 1);
            check_results($sformatf("tbl%0d", t), tbl[t].exp_fail, tbl[t].exp_ffv,
                          tbl[t].exp_ffp, tbl[t].exp_pass, msig);
            dut_sig[t] = signature;
            @(negedge clk);
            check("done_holds", done, 1);
        end
        check("sig_differs_sa1", (dut_sig[0] != dut_sig[1]), 1);

        // Randomized fault masks against the reference model
        for (int t = 0; t < 3; t++) begin
            rma = 4'($urandom); rms = 4'($urandom); rmg = 4'($urandom);
            sa0_a_mask = rma; sa1_sum_mask = rms; sa0_gen_mask = rmg;
            model_run(rma, rms, rmg, mfail, mffv, mffp, msig);
            run_bist(1'b0, bc, to);
            check_results("rand", mfail, mffv, mffp, (mfail == 0), msig);
        end

        // Asynchronous reset at RUN cycle 100
        sa0_a_mask = '0; sa1_sum_mask = 4'h1; sa0_gen_mask = '0;
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        bc = 0;
        for (int k = 0; k < 200 && bc < 101; k++) begin
            @(negedge clk);
            if (busy) bc++;
        end
        check("pre_reset_busy", busy, 1);
        rst_n = 1'b0;
        sa1_sum_mask = '0;
        #1;
        check("mid_rst_busy", busy, 0);
        check("mid_rst_done", done, 0);
        check("mid_rst_fail_count", fail_count, 0);
        check("mid_rst_ffv", first_fail_valid, 0);
        check("mid_rst_ffp", first_fail_pattern, 0);
        check("mid_rst_signature", signature, 0);
        check("mid_rst_func_sum", {func_cout, func_sum}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("post_rst_idle", busy, 0);

        model_run('0, '0, '0, mfail, mffv, mffp, msig);
        run_bist(1'b0, bc, to);
        check("post_rst_busy_cycles", bc, NPAT + 1);
        check_results("post_rst", 0, 0, 0, 1, msig);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
